// File: rtl/mpe_pkg.sv
// mpe_pkg: shared definitions for the multi-index priority encoder.
//   state_t         - controller state (IDLE: accepting a vector, EMIT: streaming indices)
//   MODE_MSB_FIRST  - encoder mode value giving the highest set bit priority
//   MODE_LSB_FIRST  - encoder mode value giving the lowest set bit priority
package mpe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic MODE_LSB_FIRST = 1'b0;
    localparam logic MODE_MSB_FIRST = 1'b1;

endpackage

// File: rtl/priority_encoder.sv
// priority_encoder: combinational priority encoder with selectable direction.
//   vec    in   WIDTH      request bits
//   mode   in   1          MODE_MSB_FIRST: highest set bit wins; MODE_LSB_FIRST: lowest wins
//   index  out  OUT_WIDTH  position of the winning bit (0 when no bit is set)
//   valid  out  1          at least one bit of vec is set
module priority_encoder
    import mpe_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned OUT_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     vec,
    input  logic                 mode,
    output logic [OUT_WIDTH-1:0] index,
    output logic                 valid
);

    always_comb begin
        index = '0;
        if (mode == MODE_MSB_FIRST) begin
            // ascending scan: the last hit is the highest set bit
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (vec[i]) index = OUT_WIDTH'(i);
            end
        end else begin
            // descending scan: the last hit is the lowest set bit
            for (int unsigned j = 0; j < WIDTH; j++) begin
                if (vec[WIDTH-1-j]) index = OUT_WIDTH'(WIDTH-1-j);
            end
        end
    end

    assign valid = |vec;

endmodule

// File: rtl/multi_priority_encoder.sv
// multi_priority_encoder: accepts a request vector and streams up to MAX_OUT
// set-bit indices in priority order, one per out_valid/out_ready beat.
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   in_valid/ready   request vector handshake; in_vec sampled on acceptance
//   out_valid/ready  index beat handshake
//   out_index        index of the current priority bit
//   out_last         final beat for this vector
//   out_none         the accepted vector had no set bits (single beat, index 0)
//   out_count        beats accepted so far for this vector
module multi_priority_encoder
    import mpe_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH = 8,
    parameter int unsigned MAX_OUT     = 2,
    parameter int unsigned MSB_FIRST   = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [INPUT_WIDTH-1:0]             in_vec,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(INPUT_WIDTH)-1:0]     out_index,
    output logic                               out_last,
    output logic                               out_none,
    output logic [$clog2(MAX_OUT+1)-1:0]       out_count
);

    localparam int unsigned OUTPUT_WIDTH = $clog2(INPUT_WIDTH);
    localparam int unsigned CNT_WIDTH    = $clog2(MAX_OUT + 1);
    localparam logic        MODE         = (MSB_FIRST != 0) ? MODE_MSB_FIRST : MODE_LSB_FIRST;

    state_t                  state, next_state;
    logic [INPUT_WIDTH-1:0]  residual, residual_next;
    logic [CNT_WIDTH-1:0]    count, count_next;
    logic [OUTPUT_WIDTH-1:0] enc_index;
    logic                    enc_valid;
    logic [INPUT_WIDTH-1:0]  clear_mask;
    logic                    single_bit;
    logic                    cap_reached;
    logic                    last;

    priority_encoder #(
        .WIDTH     (INPUT_WIDTH),
        .OUT_WIDTH (OUTPUT_WIDTH)
    ) u_encoder (
        .vec   (residual),
        .mode  (MODE),
        .index (enc_index),
        .valid (enc_valid)
    );

    // One-hot decode of the current index; used to retire that bit.
    always_comb begin
        clear_mask = '0;
        clear_mask[enc_index] = 1'b1;
    end

    assign single_bit  = enc_valid && ((residual & (residual - INPUT_WIDTH'(1))) == '0);
    assign cap_reached = (count + CNT_WIDTH'(1)) == CNT_WIDTH'(MAX_OUT);
    // An empty vector also ends after its single "none" beat.
    assign last        = cap_reached || single_bit || !enc_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            residual <= '0;
            count    <= '0;
        end else begin
            state    <= next_state;
            residual <= residual_next;
            count    <= count_next;
        end
    end

    always_comb begin
        next_state    = state;
        residual_next = residual;
        count_next    = count;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        out_index     = '0;
        out_last      = 1'b0;
        out_none      = 1'b0;
        out_count     = count;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    residual_next = in_vec;
                    count_next    = '0;
                    next_state    = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_index = enc_index;
                out_last  = last;
                out_none  = !enc_valid;
                if (out_ready) begin
                    residual_next = residual & ~clear_mask;
                    count_next    = count + CNT_WIDTH'(1);
                    if (last) next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
